// File: rtl/mac_pe_dot.sv
// mac_pe_dot: pipelined multi-lane dot-product MAC processing element.
// Each beat multiplies NumLanes operand pairs and sums them (stage 1). The
// dot products of acc_len_i beats are then accumulated (stage 2), and one
// result per segment goes out on a valid/ready port. Backpressure from the
// output port stalls the whole pipe.
// Optional feature macro: MAC_PE_DOT_SAT_EN (saturating accumulation with a
// sticky overflow flag). When it is undefined the sum wraps and overflow_o
// is tied to 0.
module mac_pe_dot #(
  parameter int InputDataWidth = 8,
  parameter int NumLanes       = 4,
  parameter int AccWidth       = 32,
  parameter int CntWidth       = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumLanes*InputDataWidth-1:0] a_i,
  input  logic [NumLanes*InputDataWidth-1:0] b_i,
  input  logic                               signed_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [CntWidth-1:0]                acc_len_i,
  input  logic                               acc_clr_i,
  output logic [AccWidth-1:0]                acc_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               busy_o,
  output logic                               overflow_o
);

  localparam int DotWidth = 2*InputDataWidth + $clog2(NumLanes);
  localparam int ExtW     = InputDataWidth + 1;
  localparam int ProdW    = 2*ExtW;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state_q, state_d;

  logic                       advance, fire;
  logic signed [DotWidth:0]   dot_sum;
  logic [DotWidth-1:0]        dot_p1;
  logic                       sgn_p1;
  logic                       vld_p1;
  logic [AccWidth-1:0]        acc_p2;
  logic [CntWidth-1:0]        cnt_q, len_q, len_eff, seg_len, cnt_nxt;
  logic [AccWidth-1:0]        dotx, sum_n;
  logic                       first, last, stage2_en, load_res;

  // One lane product. Each operand is widened by one bit (sign or zero
  // extension), so a single signed multiplier serves both modes.
  function automatic logic signed [DotWidth:0] lane_prod(
    input logic [InputDataWidth-1:0] a,
    input logic [InputDataWidth-1:0] b,
    input logic                      s
  );
    logic signed [ExtW-1:0]  ea, eb;
    logic signed [ProdW-1:0] p;
    ea = {s & a[InputDataWidth-1], a};
    eb = {s & b[InputDataWidth-1], b};
    p  = ea * eb;
    return (DotWidth+1)'(p);
  endfunction

  // Widens a registered dot product to the accumulator width using that beat's own signedness.
  function automatic logic [AccWidth-1:0] ext_dot(input logic [DotWidth-1:0] d, input logic s);
    if (s) return AccWidth'(signed'(d));
    else   return AccWidth'(d);
  endfunction

  assign advance    = !(out_valid_o && !out_ready_i);
  assign in_ready_o = advance && !rst_i;
  assign fire       = in_valid_i && in_ready_o;
  assign busy_o     = (state_q == ACCUM) || vld_p1;

  // Adder tree across all lanes.
  always_comb begin
    dot_sum = '0;
    for (int k = 0; k < NumLanes; k++) begin
      dot_sum = dot_sum + lane_prod(a_i[k*InputDataWidth +: InputDataWidth],
                                    b_i[k*InputDataWidth +: InputDataWidth], signed_i);
    end
  end

  // ---- stage 1 -> stage 2 boundary ----
  assign dotx      = ext_dot(dot_p1, sgn_p1);
  assign first     = (state_q == IDLE);
  assign len_eff   = (acc_len_i == '0) ? CntWidth'(1) : acc_len_i;
  assign seg_len   = first ? len_eff : len_q;
  assign cnt_nxt   = first ? CntWidth'(1) : cnt_q + CntWidth'(1);
  assign last      = (cnt_nxt == seg_len);
  assign stage2_en = advance && vld_p1 && !acc_clr_i;
  assign load_res  = stage2_en && last;

`ifdef MAC_PE_DOT_SAT_EN
  logic seg_sgn_q, seg_ovf_q, ovf_q, sat_hit, ovf_n;

  // Add with clamping. The top bit of the return value flags a clamp.
  function automatic logic [AccWidth:0] sat_add(
    input logic [AccWidth-1:0] x,
    input logic [AccWidth-1:0] y,
    input logic                s
  );
    logic [AccWidth:0]   w;
    logic [AccWidth-1:0] r;
    logic                o;
    if (s) begin
      w = {x[AccWidth-1], x} + {y[AccWidth-1], y};
      o = w[AccWidth] ^ w[AccWidth-1];
      if (o) r = w[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}} : {1'b0, {(AccWidth-1){1'b1}}};
      else   r = w[AccWidth-1:0];
    end else begin
      w = {1'b0, x} + {1'b0, y};
      o = w[AccWidth];
      r = o ? {AccWidth{1'b1}} : w[AccWidth-1:0];
    end
    return {o, r};
  endfunction

  // The first beat of a segment loads the accumulator directly. Later beats
  // clamp according to the signedness latched from that first beat.
  always_comb begin
    if (first) {sat_hit, sum_n} = {1'b0, dotx};
    else       {sat_hit, sum_n} = sat_add(acc_p2, dotx, seg_sgn_q);
    ovf_n = sat_hit || (!first && seg_ovf_q);
  end

  // Per-segment signedness, sticky clamp flag, and the overflow flag reported with the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_sgn_q <= 1'b0;
      seg_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (acc_clr_i) begin
        seg_ovf_q <= 1'b0;
      end else if (stage2_en) begin
        if (first) seg_sgn_q <= sgn_p1;
        seg_ovf_q <= ovf_n;
      end
      if (load_res) ovf_q <= ovf_n;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign sum_n      = first ? dotx : acc_p2 + dotx;
  assign overflow_o = 1'b0;
`endif

  // Segment FSM: the next state follows from the stage-2 beat and the abort input.
  always_comb begin
    state_d = state_q;
    if (acc_clr_i)      state_d = IDLE;
    else if (stage2_en) state_d = last ? IDLE : ACCUM;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Control: pipe valid, beat counter, latched length, and the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      cnt_q       <= '0;
      len_q       <= CntWidth'(1);
      out_valid_o <= 1'b0;
      acc_o       <= '0;
    end else begin
      if (acc_clr_i)    vld_p1 <= 1'b0;
      else if (advance) vld_p1 <= fire;
      if (acc_clr_i) begin
        cnt_q <= '0;
      end else if (stage2_en) begin
        cnt_q <= last ? '0 : cnt_nxt;
        if (first) len_q <= len_eff;
      end
      if (advance) begin
        out_valid_o <= load_res;
        if (load_res) acc_o <= sum_n;
      end
    end
  end

  // Datapath registers. These carry no reset because the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      dot_p1 <= dot_sum[DotWidth-1:0];
      sgn_p1 <= signed_i;
    end
    if (acc_clr_i)      acc_p2 <= '0;
    else if (stage2_en) acc_p2 <= sum_n;
  end

endmodule
